// File: rtl/circle_pkg.sv
// Shared constants and types for the circle sprite RAM controller.
// RAM address layout: {frame, row[3:0], col[3:0]}.
package circle_pkg;
    localparam int AW       = 9;
    localparam int DW       = 3;
    localparam int SPR_LOG2 = 4;
    localparam int XW       = 8;
    localparam int YW       = 8;

    localparam logic [DW-1:0] TRANSP = 3'b000;

    typedef enum logic {IDLE, CLEAR} wr_state_t;
    typedef logic [AW-1:0] ram_addr_t;
endpackage

// File: rtl/circle_addr_gen.sv
// Render stages 0/1: sprite bounding-box test on the incoming pixel and
// registered RAM read address / read enable.
module circle_addr_gen
    import circle_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic [XW-1:0] spr_x,
    input  logic [YW-1:0] spr_y,
    input  logic          frame_sel,
    output logic          valid_q,
    output logic          ram_re,
    output ram_addr_t     ram_raddr
);
    logic [XW:0] dx;
    logic [YW:0] dy;
    logic        in_box;

    // The extra top bit catches the borrow, so pixels left of or above the
    // sprite fail the box test instead of wrapping into it.
    always_comb begin
        dx     = {1'b0, pix_x} - {1'b0, spr_x};
        dy     = {1'b0, pix_y} - {1'b0, spr_y};
        in_box = pix_valid && (dx[XW:SPR_LOG2] == '0) && (dy[YW:SPR_LOG2] == '0);
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ram_re    <= 1'b0;
            ram_raddr <= '0;
        end else begin
            valid_q   <= pix_valid;
            ram_re    <= in_box;
            ram_raddr <= {frame_sel, dy[SPR_LOG2-1:0], dx[SPR_LOG2-1:0]};
        end
    end
endmodule

// File: rtl/circle_ram_ctrl.sv
// Circle sprite RAM controller: 2-cycle render read pipeline plus arbitration
// of the single write port between the host and the bulk-clear engine.
module circle_ram_ctrl
    import circle_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic [XW-1:0] spr_x,
    input  logic [YW-1:0] spr_y,
    input  logic          frame_sel,
    output logic          out_valid,
    output logic          out_hit,
    output logic [DW-1:0] out_color,
    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          host_ack,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_value,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
);
    logic valid_q;
    logic box_q2;

    circle_addr_gen u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .frame_sel (frame_sel),
        .valid_q   (valid_q),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr)
    );

    // Stage 2: ram_rdata is already registered inside the RAM, so hit/colour
    // are formed directly from it against the piped box flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            box_q2    <= 1'b0;
        end else begin
            out_valid <= valid_q;
            box_q2    <= ram_re;
        end
    end

    assign out_hit   = box_q2 && (ram_rdata != TRANSP);
    assign out_color = out_hit ? ram_rdata : TRANSP;

    // Write-port FSM. cnt has one extra bit: cnt[AW] marks "all 512 issued".
    wr_state_t       state, state_n;
    logic [AW:0]     cnt, cnt_n;
    logic [DW-1:0]   clr_val, clr_val_n;
    logic            we_n, ack_n, busy_n, done_n;
    logic [AW-1:0]   waddr_n;
    logic [DW-1:0]   wdata_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_val    <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            host_ack   <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            clr_val    <= clr_val_n;
            ram_we     <= we_n;
            ram_waddr  <= waddr_n;
            ram_wdata  <= wdata_n;
            host_ack   <= ack_n;
            clear_busy <= busy_n;
            clear_done <= done_n;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        clr_val_n = clr_val;
        we_n      = 1'b0;
        waddr_n   = ram_waddr;
        wdata_n   = ram_wdata;
        ack_n     = 1'b0;
        busy_n    = clear_busy;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_n   = CLEAR;
                    cnt_n     = '0;
                    clr_val_n = clear_value;
                    busy_n    = 1'b1;
                end else if (host_req && !host_ack) begin
                    // Gating on host_ack limits a held request to one write per 2 cycles.
                    we_n    = 1'b1;
                    waddr_n = host_addr;
                    wdata_n = host_data;
                    ack_n   = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt[AW]) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = cnt[AW-1:0];
                    wdata_n = clr_val;
                    cnt_n   = cnt + (AW+1)'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_circle_ram_ctrl.sv
// Self-checking bench for circle_ram_ctrl: table vectors, random render
// stream against a coordinate-level model, and write/clear sequences.
module tb_circle_ram_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       pix_valid, frame_sel;
    logic [7:0] pix_x, pix_y, spr_x, spr_y;
    logic       out_valid, out_hit;
    logic [2:0] out_color;
    logic       host_req, host_ack;
    logic [8:0] host_addr;
    logic [2:0] host_data;
    logic       clear_start, clear_busy, clear_done;
    logic [2:0] clear_value;
    logic       ram_we, ram_re;
    logic [8:0] ram_waddr, ram_raddr;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata = 3'b000;
    logic       load;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] mem    [512];
    logic [2:0] shadow [512];

    always #5 clock = ~clock;

    circle_ram_ctrl dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .spr_x(spr_x), .spr_y(spr_y), .frame_sel(frame_sel),
        .out_valid(out_valid), .out_hit(out_hit), .out_color(out_color),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    // 512x3 RAM with registered read, old data on a same-address collision.
    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 512; i++) mem[i] <= 3'(i);
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pure coordinate arithmetic over unbounded integers.
    function automatic void ref_pix(input int v, input int px, input int py, input int sx,
                                    input int sy, input int f, output int hit, output int col);
        int cx, ry;
        cx = px - sx;
        ry = py - sy;
        hit = 0;
        col = 0;
        if (v != 0 && cx >= 0 && cx < 16 && ry >= 0 && ry < 16) begin
            col = int'(shadow[f * 256 + ry * 16 + cx]);
            if (col != 0) hit = 1;
        end
    endfunction

    typedef struct {
        int v, hit, col;
    } exp_t;

    task automatic render_random(input int n);
        exp_t q[$];
        exp_t e;
        int sx, sy, tx, ty, f, v;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clock);
            if (q.size() == 2) begin
                e = q.pop_front();
                check("rnd_valid", int'(out_valid), e.v);
                check("rnd_hit", int'(out_hit), e.hit);
                check("rnd_color", int'(out_color), e.col);
            end
            sx = int'($urandom_range(0, 255));
            sy = int'($urandom_range(0, 239));
            tx = (sx + int'($urandom_range(0, 40)) - 12) & 255;
            ty = (sy + int'($urandom_range(0, 40)) - 12) & 255;
            f  = int'($urandom_range(0, 1));
            v  = (i < n) ? int'($urandom_range(0, 3) != 0) : 0;
            pix_valid = v[0];
            pix_x = 8'(tx); pix_y = 8'(ty); spr_x = 8'(sx); spr_y = 8'(sy);
            frame_sel = f[0];
            e.v = v;
            ref_pix(v, tx, ty, sx, sy, f, e.hit, e.col);
            q.push_back(e);
        end
        pix_valid = 1'b0;
    endtask

    task automatic host_write(input logic [8:0] a, input logic [2:0] d);
        @(negedge clock);
        host_req = 1'b1; host_addr = a; host_data = d;
        @(negedge clock);
        check("hw_ack", int'(host_ack), 1);
        check("hw_we", int'(ram_we), 1);
        check("hw_waddr", int'(ram_waddr), int'(a));
        check("hw_wdata", int'(ram_wdata), int'(d));
        host_req = 1'b0;
        @(negedge clock);
        check("hw_ack_pulse", int'(host_ack), 0);
        check("hw_we_off", int'(ram_we), 0);
        shadow[a] = d;
    endtask

    task automatic full_clear(input logic [2:0] val);
        int writes;
        int got_done;
        writes = 0;
        got_done = 0;
        @(negedge clock);
        clear_start = 1'b1; clear_value = val;
        @(negedge clock);
        clear_start = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clock);
            if (ram_we) writes++;
            if (clear_done) begin got_done = 1; break; end
        end
        check("fc_done", got_done, 1);
        check("fc_writes", writes, 512);
        for (int i = 0; i < 512; i++) shadow[i] = val;
    endtask

    typedef struct {
        logic v; logic [7:0] px, py, sx, sy; logic f;
        logic re; logic [8:0] ra; logic hit; logic [2:0] col;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int acks, prev, consec, exp_addr, bad, last_wr, done_cyc, ack_bad, busy_at_done, got, cnt;

        tbl[0]  = '{1'b1, 8'd101, 8'd51,  8'd100, 8'd50,  1'b0, 1'b1, 9'h011, 1'b1, 3'b101};
        tbl[1]  = '{1'b1, 8'd255, 8'd50,  8'd250, 8'd50,  1'b0, 1'b1, 9'h005, 1'b1, 3'b101};
        tbl[2]  = '{1'b1, 8'd0,   8'd50,  8'd250, 8'd50,  1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
        tbl[3]  = '{1'b1, 8'd108, 8'd50,  8'd100, 8'd50,  1'b0, 1'b1, 9'h008, 1'b0, 3'b000};
        tbl[4]  = '{1'b1, 8'd15,  8'd15,  8'd0,   8'd0,   1'b1, 1'b1, 9'h1FF, 1'b1, 3'b110};
        tbl[5]  = '{1'b1, 8'd99,  8'd50,  8'd100, 8'd50,  1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
        tbl[6]  = '{1'b1, 8'd100, 8'd49,  8'd100, 8'd50,  1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 8'd115, 8'd65,  8'd100, 8'd50,  1'b0, 1'b1, 9'h0FF, 1'b1, 3'b111};
        tbl[8]  = '{1'b1, 8'd116, 8'd50,  8'd100, 8'd50,  1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
        tbl[9]  = '{1'b0, 8'd101, 8'd51,  8'd100, 8'd50,  1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
        tbl[10] = '{1'b1, 8'd3,   8'd239, 8'd0,   8'd230, 1'b0, 1'b1, 9'h093, 1'b1, 3'b011};
        tbl[11] = '{1'b1, 8'd3,   8'd0,   8'd0,   8'd230, 1'b0, 1'b0, 9'h000, 1'b0, 3'b000};

        for (int i = 0; i < 512; i++) shadow[i] = 3'(i);

        reset = 1'b1; load = 1'b1;
        pix_valid = 1'b1; pix_x = 8'd1; pix_y = 8'd0; spr_x = 8'd0; spr_y = 8'd0; frame_sel = 1'b0;
        host_req = 1'b0; host_addr = '0; host_data = '0;
        clear_start = 1'b0; clear_value = '0;
        @(negedge clock);
        @(negedge clock);
        load = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(clear_busy), 0);
        reset = 1'b0;

        // Stream in-box pixels, then reset mid-stream.
        repeat (3) @(negedge clock);
        check("stream_valid", int'(out_valid), 1);
        check("stream_color", int'(out_color), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_hit", int'(out_hit), 0);
        check("mid_rst_color", int'(out_color), 0);
        check("mid_rst_re", int'(ram_re), 0);
        check("mid_rst_raddr", int'(ram_raddr), 0);
        check("mid_rst_wr", int'({ram_we, host_ack, clear_busy, clear_done}), 0);
        check("mid_rst_wa", int'({ram_waddr, ram_wdata}), 0);
        @(negedge clock);
        check("rst_hold_valid", int'(out_valid), 0);
        reset = 1'b0; pix_valid = 1'b0;
        @(negedge clock);
        check("post_rst_idle", int'(out_valid), 0);
        pix_valid = 1'b1;
        @(negedge clock);
        check("post_rst_n1", int'(out_valid), 0);
        pix_valid = 1'b0;
        @(negedge clock);
        check("post_rst_n2", int'(out_valid), 1);
        check("post_rst_hit", int'(out_hit), 1);

        host_write(9'h011, 3'b101);
        host_write(9'h1FF, 3'b110);

        // Held request: one write every two cycles.
        @(negedge clock);
        host_req = 1'b1; host_addr = 9'h1FF; host_data = 3'b110;
        acks = 0; prev = 0; consec = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (host_ack) acks++;
            if (host_ack && prev != 0) consec++;
            prev = int'(host_ack);
        end
        host_req = 1'b0;
        check("held_acks", acks, 3);
        check("held_spacing", consec, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            pix_valid = tbl[i].v; pix_x = tbl[i].px; pix_y = tbl[i].py;
            spr_x = tbl[i].sx; spr_y = tbl[i].sy; frame_sel = tbl[i].f;
            @(negedge clock);
            pix_valid = 1'b0;
            check($sformatf("tbl%0d_re", i), int'(ram_re), int'(tbl[i].re));
            if (tbl[i].re) check($sformatf("tbl%0d_raddr", i), int'(ram_raddr), int'(tbl[i].ra));
            @(negedge clock);
            check($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_hit", i), int'(out_hit), int'(tbl[i].hit));
            check($sformatf("tbl%0d_color", i), int'(out_color), int'(tbl[i].col));
        end

        render_random(200);

        // Clear with a held host request: clear wins, host waits.
        @(negedge clock);
        clear_start = 1'b1; clear_value = 3'b000;
        host_req = 1'b1; host_addr = 9'h055; host_data = 3'b111;
        @(negedge clock);
        clear_start = 1'b0;
        check("clr_busy", int'(clear_busy), 1);
        check("clr_no_ack", int'(host_ack), 0);
        exp_addr = 0; bad = 0; last_wr = -1; done_cyc = -1; ack_bad = 0; busy_at_done = 1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clock);
            if (host_ack) ack_bad++;
            if (ram_we) begin
                if (int'(ram_waddr) != exp_addr || ram_wdata != 3'b000) bad++;
                if (exp_addr > 0 && last_wr != c - 1) bad++;
                exp_addr++;
                last_wr = c;
            end
            if (clear_done) begin
                done_cyc = c;
                busy_at_done = int'(clear_busy);
                break;
            end
        end
        check("clr_writes", exp_addr, 512);
        check("clr_seq", bad, 0);
        check("clr_done_timing", done_cyc, last_wr + 1);
        check("clr_busy_at_done", busy_at_done, 0);
        check("clr_ack_during", ack_bad, 0);
        got = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (clear_done) bad++;
            if (host_ack) begin
                got = 1;
                check("clr_host_waddr", int'(ram_waddr), 9'h055);
                break;
            end
        end
        host_req = 1'b0;
        check("clr_host_ack", got, 1);
        check("clr_done_pulse", bad, 0);
        for (int i = 0; i < 512; i++) shadow[i] = 3'b000;
        shadow[9'h055] = 3'b111;

        render_random(150);

        full_clear(3'b011);

        // Abort a clear with reset after address 199 has been written.
        @(negedge clock);
        clear_start = 1'b1; clear_value = 3'b101;
        @(negedge clock);
        clear_start = 1'b0;
        got = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (ram_we && ram_waddr == 9'd199) begin got = 1; break; end
        end
        check("abort_reached", got, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(clear_busy), 0);
        check("abort_we", int'(ram_we), 0);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (clear_done || clear_busy || ram_we) cnt++;
        end
        check("abort_quiet", cnt, 0);
        for (int i = 0; i < 512; i++) shadow[i] = (i < 200) ? 3'b101 : 3'b011;
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== shadow[i]) bad++;
        check("abort_contents", bad, 0);

        render_random(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
